// File: rtl/sm_debounce.sv
// ---------------------------------------------------------------------------
// sm_debounce
//
// This block conditions the DE0-Nano KEY/SW pins into clean control levels
// for the core. Each raw pin goes through the following path:
//   - a 2-flop synchronizer,
//   - a polarity flip for active-low pins,
//   - a change filter that accepts a new value only after it has held for
//     DEBOUNCE_CYCLES consecutive cycles.
// An accepted change updates `level` and emits a one-cycle `rise` or `fall`
// pulse. Every output comes straight from a flop.
//
// Optional feature macro: SM_DEBOUNCE_REPEAT_EN
//   When defined, a held-high level re-emits `rise` every REPEAT_CYCLES
//   cycles after the accepted press (auto-repeat).
//   When undefined, no repeat logic exists and REPEAT_CYCLES is ignored.
//
// Parameters:
//   N_IN             number of conditioned inputs
//   DEBOUNCE_CYCLES  stable cycles required to accept a change (>= 2)
//   INV_MASK         bit set = pin is active-low, inverted after sync
//   REPEAT_CYCLES    auto-repeat interval (>= 2, only with the macro)
//
// Ports:
//   clk     in   board clock, the only clock
//   rst     in   synchronous active-high reset
//   raw_in  in   [N_IN]  asynchronous pin levels
//   level   out  [N_IN]  debounced, polarity-corrected level
//   rise    out  [N_IN]  one-cycle pulse on accepted 0->1 (or auto-repeat)
//   fall    out  [N_IN]  one-cycle pulse on accepted 1->0
// ---------------------------------------------------------------------------
module sm_debounce #(
    parameter int                N_IN            = 6,
    parameter int                DEBOUNCE_CYCLES = 500000,
    parameter logic [N_IN-1:0]   INV_MASK        = 6'b000011,
    parameter int                REPEAT_CYCLES   = 25000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_IN-1:0] raw_in,
    output logic [N_IN-1:0] level,
    output logic [N_IN-1:0] rise,
    output logic [N_IN-1:0] fall
);

    // The counter only ever needs to reach DEBOUNCE_CYCLES-1, because it
    // clears at the terminal count.
    localparam int              CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [N_IN-1:0] r_s1;
    logic [N_IN-1:0] r_s2;
    logic [N_IN-1:0] r_stable;
    logic [N_IN-1:0] r_rise;
    logic [N_IN-1:0] r_fall;
    logic [CW-1:0]   r_cnt [N_IN];

    logic [N_IN-1:0] w_c;
    logic [N_IN-1:0] w_accept;

    // ------------------------------------------------------------------
    // Synchronizer. Reset loads the inactive pin level, so active-low
    // pins do not look pressed right after reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= INV_MASK;
            r_s2 <= INV_MASK;
        end else begin
            r_s1 <= raw_in;
            r_s2 <= r_s1;
        end
    end

    assign w_c = r_s2 ^ INV_MASK;

    // A bit is accepted once it has differed from the stable value for
    // DEBOUNCE_CYCLES consecutive cycles.
    always_comb begin
        w_accept = '0;
        for (int i = 0; i < N_IN; i++) begin
            w_accept[i] = (w_c[i] != r_stable[i]) && (r_cnt[i] == CNT_LAST);
        end
    end

`ifdef SM_DEBOUNCE_REPEAT_EN
    localparam int            RW       = $clog2(REPEAT_CYCLES);
    localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] r_rcnt [N_IN];
`else
    // Keeps the parameter referenced when the repeat logic is not built.
    logic w_unused_repeat;
    assign w_unused_repeat = (REPEAT_CYCLES > 0);
`endif

    // ------------------------------------------------------------------
    // Debounce filter and pulse generation
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stable <= '0;
            r_rise   <= '0;
            r_fall   <= '0;
            for (int i = 0; i < N_IN; i++) begin
                r_cnt[i] <= '0;
`ifdef SM_DEBOUNCE_REPEAT_EN
                r_rcnt[i] <= '0;
`endif
            end
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                r_rise[i] <= 1'b0;
                r_fall[i] <= 1'b0;

                // A return to the stable value discards any partial count.
                if (w_c[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_accept[i]) begin
                    r_stable[i] <= w_c[i];
                    r_cnt[i]    <= '0;
                    r_rise[i]   <= w_c[i];
                    r_fall[i]   <= ~w_c[i];
                end else begin
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                end

`ifdef SM_DEBOUNCE_REPEAT_EN
                // The repeat counter runs only while the level is high.
                // An accepted release takes priority, so rise and fall are
                // never high together.
                if (!r_stable[i] || w_accept[i]) begin
                    r_rcnt[i] <= '0;
                end else if (r_rcnt[i] == RPT_LAST) begin
                    r_rcnt[i] <= '0;
                    r_rise[i] <= 1'b1;
                end else begin
                    r_rcnt[i] <= r_rcnt[i] + RW'(1);
                end
`endif
            end
        end
    end

    assign level = r_stable;
    assign rise  = r_rise;
    assign fall  = r_fall;

endmodule

// File: tb/tb_sm_debounce.sv
// ---------------------------------------------------------------------------
// tb_sm_debounce
//
// Directed bench for sm_debounce with DEBOUNCE_CYCLES=4 and REPEAT_CYCLES=10.
// A window-based reference model predicts level/rise/fall on every cycle:
// a change is accepted when the last DEBOUNCE_CYCLES compared samples all
// differ from the current level. Literal hand-computed checks at key edges
// pin the model itself.
// ---------------------------------------------------------------------------
module tb_sm_debounce;

    localparam int         N   = 6;
    localparam int         D   = 4;
    localparam int         R   = 10;
    localparam logic [5:0] INV = 6'b000011;
`ifdef SM_DEBOUNCE_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] raw_in;
    logic [5:0] level;
    logic [5:0] rise;
    logic [5:0] fall;

    int n_checks = 0;
    int n_fail   = 0;

    sm_debounce #(
        .N_IN            (N),
        .DEBOUNCE_CYCLES (D),
        .INV_MASK        (INV),
        .REPEAT_CYCLES   (R)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .raw_in (raw_in),
        .level  (level),
        .rise   (rise),
        .fall   (fall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: sliding window of compared samples per bit
    // ------------------------------------------------------------------
    logic [5:0]   m_s1, m_s2, m_c, m_lev, m_rise, m_fall;
    logic [D-1:0] m_win  [N];
    int           m_seen [N];
    int           m_held [N];

    always @(posedge clk) begin
        if (rst) begin
            m_s1   = INV;
            m_s2   = INV;
            m_lev  = '0;
            m_rise = '0;
            m_fall = '0;
            for (int i = 0; i < N; i++) begin
                m_win[i]  = '0;
                m_seen[i] = 0;
                m_held[i] = 0;
            end
        end else begin
            m_c    = m_s2 ^ INV;
            m_s2   = m_s1;
            m_s1   = raw_in;
            m_rise = '0;
            m_fall = '0;
            for (int i = 0; i < N; i++) begin
                m_win[i] = {m_win[i][D-2:0], m_c[i]};
                if (m_seen[i] < D) m_seen[i]++;
                if (m_seen[i] >= D && m_win[i] == {D{~m_lev[i]}}) begin
                    m_lev[i]  = m_c[i];
                    m_rise[i] = m_c[i];
                    m_fall[i] = ~m_c[i];
                    m_held[i] = 0;
                end else if (REP && m_lev[i]) begin
                    m_held[i]++;
                    if (m_held[i] % R == 0) m_rise[i] = 1'b1;
                end
            end
        end
        #1;
        chk("model_level", level, m_lev);
        chk("model_rise",  rise,  m_rise);
        chk("model_fall",  fall,  m_fall);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    int cnt_r, cnt_f;

    initial begin
        rst    = 1'b1;
        raw_in = 6'b000011;
        tick(2);
        chk("reset_level", level, 6'b0);
        chk("reset_rise",  rise,  6'b0);
        chk("reset_fall",  fall,  6'b0);

        // Clean press of KEY0 (active-low)
        rst       = 1'b0;
        raw_in[0] = 1'b0;
        tick(5);
        chk("press_early_level", level[0], 1'b0);
        tick(1);
        chk("press_level", level[0], 1'b1);
        chk("press_rise",  rise,     6'b000001);
        tick(1);
        chk("press_rise_clear", rise[0], 1'b0);

        // Release of KEY0
        raw_in[0] = 1'b1;
        tick(5);
        chk("release_early_level", level[0], 1'b1);
        tick(1);
        chk("release_fall",  fall,     6'b000001);
        chk("release_level", level[0], 1'b0);
        tick(1);
        chk("release_fall_clear", fall[0], 1'b0);

        // Glitch on SW0 (bit 2) shorter than the filter
        raw_in[2] = 1'b1;
        tick(3);
        raw_in[2] = 1'b0;
        tick(8);
        chk("glitch_level", level[2], 1'b0);
        raw_in[2] = 1'b1;
        tick(5);
        chk("hold_early_rise", rise[2], 1'b0);
        tick(1);
        chk("hold_rise",  rise[2],  1'b1);
        chk("hold_level", level[2], 1'b1);
        raw_in[2] = 1'b0;
        tick(8);
        chk("hold_released", level[2], 1'b0);

        // Several switches change together
        raw_in[5:2] = 4'b1010;
        tick(5);
        chk("simul_early_rise", rise, 6'b0);
        tick(1);
        chk("simul_rise",  rise[5:2],  4'b1010);
        chk("simul_level", level[5:2], 4'b1010);
        tick(2);

        // Reset in the middle of a KEY1 count
        raw_in[1] = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(1);
        chk("midrst_level", level, 6'b0);
        chk("midrst_rise",  rise,  6'b0);
        tick(1);
        chk("midrst_fall", fall, 6'b0);
        rst = 1'b0;
        tick(5);
        chk("midrst_early_rise", rise[1], 1'b0);
        tick(1);
        chk("midrst_rise_after", rise,  6'b101010);
        chk("midrst_level_after", level, 6'b101010);
        raw_in[1] = 1'b1;
        tick(8);

        // Hold SW2 (bit 4): one rise, plus repeats when enabled
        raw_in[4] = 1'b1;
        cnt_r = 0;
        for (int k = 0; k < 35; k++) begin
            tick(1);
            cnt_r += int'(rise[4]);
        end
        chk("hold_rise_count", cnt_r, REP ? 3 : 1);
        raw_in[4] = 1'b0;
        cnt_r = 0;
        cnt_f = 0;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            cnt_r += int'(rise[4]);
            cnt_f += int'(fall[4]);
        end
        chk("release_rise_count", cnt_r, REP ? 1 : 0);
        chk("release_fall_count", cnt_f, 1);
        chk("release_level4", level[4], 1'b0);
        tick(5);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

// File: doc/sm_debounce.md
# sm_debounce

Input conditioner between the DE0-Nano board pins (KEY, SW) and the core top-level controls (rst_n, clkEnable, regAddr). Each raw input is passed through a 2-flop synchronizer and optionally inverted, then accepted only after it holds a new value for a programmable number of cycles. The block outputs a clean level per input plus one-cycle rise and fall pulses. The pulses allow single-stepping and register selection without contact bounce.

## Interface
- `N_IN`, 6: number of conditioned inputs (KEY[1:0] plus SW[3:0]).
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles required to accept a change (10 ms at 50 MHz). Must be ≥ 2.
- `INV_MASK`, 6'b000011: bit set means that input is active-low and is inverted after synchronization.
- `REPEAT_CYCLES`, 25000000: auto-repeat interval. Used only with `SM_DEBOUNCE_REPEAT_EN`.
- `clk`, in, 1: board clock; the only clock.
- `rst`, in, 1: synchronous, active-high reset.
- `raw_in`, in, N_IN: asynchronous pin levels.
- `level`, out, N_IN: debounced, polarity-corrected level.
- `rise`, out, N_IN: one-cycle pulse when `level` bit goes 0→1, or on auto-repeat.
- `fall`, out, N_IN: one-cycle pulse when `level` bit goes 1→0.

## Operation
- Each bit has independent state: `s1`, `s2` (synchronizer), `stable`, and `cnt`. `cnt` is `$clog2(DEBOUNCE_CYCLES)` bits wide.
- The compared value is `c = s2 ^ INV_MASK[i]`.
- Per bit, per cycle:
  - If `c == stable`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `stable <= c`, `cnt <= 0`, and pulse `rise` (if c=1) or `fall` (if c=0).
  - Else: `cnt <= cnt + 1`.
- Any return of `c` to `stable` before the terminal count discards the partial count. A glitch shorter than DEBOUNCE_CYCLES cycles never reaches `level`.
- `level = stable`. `rise` and `fall` are registered and high for exactly one cycle. They are never both high on the same bit.
- Bits are fully independent. Simultaneous transitions on several bits produce simultaneous pulses.
- Reset values (on `rst`, at a clock edge):
  - `s1`, `s2` <= `INV_MASK` (the inactive pin level).
  - `stable`, `cnt`, `rise`, `fall` <= 0.
  - Repeat counters <= 0.
- Reset mid-count or mid-repeat aborts the count with no pulse. An input already held active at reset release is accepted DEBOUNCE_CYCLES+2 cycles later with a `rise` pulse.

## Timing
- A raw change present before edge E enters `s1` at E and `s2` at E+1.
- If held, `level` and the pulse update at edge E+1+DEBOUNCE_CYCLES. Total latency is DEBOUNCE_CYCLES+2 edges from the first sampling edge.
- `rise`/`fall` rise and drop together with the `level` update, and clear on the next edge.
- No combinational path from `raw_in` to any output. All outputs come directly from flops.
- Counter width covers DEBOUNCE_CYCLES-1 exactly. The counter never wraps because it clears at the terminal count.

## Configuration
- Macro: `SM_DEBOUNCE_REPEAT_EN`.
- Defined:
  - Each bit gets a repeat counter, active only while `level`=1.
  - When it reaches REPEAT_CYCLES-1, it emits a `rise` pulse and clears. Repeats therefore occur at REPEAT_CYCLES, 2·REPEAT_CYCLES, … after the accepted press.
  - The counter clears whenever `level`=0 or on `rst`.
  - `fall` is unaffected.
- Undefined: no repeat logic is generated. `rise` fires only on the accepted 0→1 transition, and REPEAT_CYCLES is ignored.

## Test plan
Bench uses N_IN=6, DEBOUNCE_CYCLES=4, INV_MASK=6'b000011, REPEAT_CYCLES=10.

1. **Clean press:** `rst` for 2 cycles with raw_in=6'b000011, then raw_in[0]=0 before edge E → `level[0]`=1 and `rise[0]`=1 at edge E+5, `rise[0]`=0 at E+6. No other outputs toggle.
2. **Glitch rejection:** raw_in[2]=1 for 3 cycles, then back to 0 → `level[2]` stays 0 and no pulses. Then hold raw_in[2]=1 for 6 cycles → single `rise[2]`.
3. **Release:** after scenario 1, raw_in[0]=1 → `fall[0]` one-cycle pulse and `level[0]`=0, DEBOUNCE_CYCLES+2 edges later.
4. **Simultaneous inputs:** raw_in[5:2]=4'b1010 applied on one cycle → `rise[5]` and `rise[3]` pulse on the same cycle; `level[5:2]`=4'b1010.
5. **Reset mid-count:** raw_in[1]=0, assert `rst` after 3 cycles, release → no pulse during reset. Outputs are 0 while `rst`=1. `rise[1]` arrives 6 edges after release.
6. **Auto-repeat (`SM_DEBOUNCE_REPEAT_EN` defined):** hold raw_in[4]=1 → initial `rise[4]`, then pulses every 10 cycles. Release → `fall[4]`, no further rises. With the macro undefined → exactly one `rise[4]`.
